// File: rtl/sw_pkg.sv
// Shared defaults for the slide-switch input conditioning path.
package sw_pkg;
  localparam int unsigned SW_WIDTH           = 16;
  localparam int unsigned SW_DEBOUNCE_CYCLES = 20000;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: 2-FF synchroniser, stability counter, debounced level and change pulse.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned CNT_MAX = SW_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic sw_o,
  output logic changed_o,
  output logic change_c
);

  localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_q, sw_d;
  logic             changed_q, changed_d;

  // A mismatch must persist CNT_MAX edges; any match drops back to stable.
  always_comb begin
    s1_d      = raw_i;
    s2_d      = s1_q;
    cnt_d     = '0;
    sw_d      = sw_q;
    changed_d = 1'b0;
    if (s2_q != sw_q) begin
      if (cnt_q == CNT_LAST) begin
        sw_d      = s2_q;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      sw_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
    end
  end

  assign sw_o      = sw_q;
  assign changed_o = changed_q;
  // Next-cycle pulse, so the parent can register an aggregate in step with changed_o.
  assign change_c  = changed_d;

endmodule

// File: rtl/sw_debouncer.sv
// Debounces WIDTH slide-switch lines and flags every accepted toggle with one-cycle pulses.
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH   = SW_WIDTH,
  parameter int unsigned CNT_MAX = SW_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_changed_o,
  output logic             any_changed_o
);

  logic [WIDTH-1:0] change_c;
  logic             any_changed_q, any_changed_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .CNT_MAX (CNT_MAX)
    ) u_bit (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .raw_i     (sw_raw_i[g]),
      .sw_o      (sw_o[g]),
      .changed_o (sw_changed_o[g]),
      .change_c  (change_c[g])
    );
  end

  // OR of the per-bit next pulses so any_changed_o lines up with sw_changed_o.
  always_comb begin
    any_changed_d = |change_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      any_changed_q <= 1'b0;
    end else begin
      any_changed_q <= any_changed_d;
    end
  end

  assign any_changed_o = any_changed_q;

endmodule
